uart_word_loader: RTL and testbench
===================================

Name: uart_word_loader

Overview:
- Serial front end that sits directly upstream of the CPU's UART load interface.
- Receives 8N1 UART bytes on `rx` and assembles 3-byte frames: a header byte followed by a 16-bit word, high byte first.
- For each good frame it drives `uart_en`, `uart_data` and `uart_sel` into the CPU.
- Flags framing, protocol and timeout errors, and resynchronises on its own.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 8.
- TIMEOUT_CLKS, 200000, idle cycles allowed between bytes of one frame before the frame is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx  in  1  UART serial input; idles high; asynchronous to clk
- uart_en  out  1  one-cycle strobe: a word is valid on uart_data/uart_sel
- uart_data  out  16  assembled word; held until the next strobe
- uart_sel  out  2  load target taken from the header; held until the next strobe
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- proto_err  out  1  one-cycle pulse: bad header byte, or inter-byte timeout
- busy  out  1  high while any frame byte is pending or being received
- word_cnt  out  16  count of words delivered; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, both FSMs go to their idle states, all counters clear, both synchroniser flops are set to 1.
- `rx` passes through a 2-flop synchroniser; all logic uses the synchronised value `rxs`.
- Byte receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI:
  - R_IDLE: `rxs`=0 -> R_START and load the bit counter.
  - R_START: after CLKS_PER_BIT/2 cycles (integer division), resample. Low -> R_DATA. High -> false start, back to R_IDLE with no error.
  - R_DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles, then -> R_STOP.
  - R_STOP: sample once after CLKS_PER_BIT cycles.
    - High: byte_valid pulses for 1 cycle; -> R_IDLE.
    - Low: frame_err pulses, the byte is discarded, the assembler is forced to A_HDR; -> R_WAITHI.
  - R_WAITHI: stay until `rxs`=1 (break condition), then -> R_IDLE.
- Frame assembler FSM, states A_HDR, A_HI, A_LO:
  - A_HDR: on byte_valid, a header is valid when byte[7:2]==6'b101010.
    - Valid: latch sel=byte[1:0]; -> A_HI.
    - Invalid: proto_err pulses; stay in A_HDR.
  - A_HI: on byte_valid, latch the high byte; -> A_LO.
  - A_LO: on byte_valid, all of the following happen in the next cycle: uart_data={hi,byte}, uart_sel=latched sel, uart_en=1 for exactly one cycle, word_cnt increments. State -> A_HDR.
  - Latency: uart_en rises 1 clk after the stop-bit sample of the low byte.
- Timeout:
  - In A_HI or A_LO the counter runs while the receiver is in R_IDLE. It clears on any start detect.
  - On reaching TIMEOUT_CLKS: proto_err pulses and the assembler goes to A_HDR. Latched sel and hi are discarded; uart_data/uart_sel are unchanged.
- Simultaneous events:
  - frame_err takes precedence over any assembler update in the same cycle.
  - A timeout and a start detect in the same cycle: the start detect wins and no timeout occurs.
- busy = (receiver != R_IDLE) OR (assembler != A_HDR).
- uart_en is never asserted for two consecutive cycles. Frames shorter than 3 bytes never produce a strobe.
- Reset asserted mid-byte or mid-frame: the partial frame is lost and no strobe is issued after release. After release, the first falling edge starts a fresh byte.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CLKS=1000):
- Send 0xA9, 0x12, 0x34 -> single uart_en pulse, uart_data=0x1234, uart_sel=2'b01, word_cnt=1, no error pulses, busy low 1 clk after the strobe.
- Send 0x55 then 0xA8, 0xBE, 0xEF -> proto_err pulses once after 0x55; then uart_en with 0xBEEF, sel=0, word_cnt=1.
- Send 0xAB, then 0x12 with its stop bit forced low, then 0xAB, 0x00, 0xFF -> frame_err pulses once; rx held low 40 clks leaves the receiver in R_WAITHI; the following frame yields uart_data=0x00FF, sel=3.
- Send 0xAA, 0x77, then stay idle 1200 clks -> proto_err at timeout, no uart_en; the next 0xA8, 0x01, 0x02 yields 0x0102.
- Glitch rx low for 4 clks while idle -> no byte, no error, busy returns to 0.
- Assert reset during the 2nd data byte, release, then send 0xA9, 0xCA, 0xFE -> all outputs 0 during reset; exactly one strobe afterwards with 0xCAFE, word_cnt=1.

Source files
------------

// File: rtl/uart_word_loader.sv
// UART 8N1 receiver plus frame assembler: header byte (sel) + 16-bit word, high byte first.
// Delivers each good frame to the CPU load interface as a one-cycle uart_en strobe.
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        uart_en,
    output logic [15:0] uart_data,
    output logic [1:0]  uart_sel,
    output logic        frame_err,
    output logic        proto_err,
    output logic        busy,
    output logic [15:0] word_cnt
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [5:0]       HDR_TAG   = 6'b101010;

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_START  = 3'd1,
        R_DATA   = 3'd2,
        R_STOP   = 3'd3,
        R_WAITHI = 3'd4
    } r_state_t;

    typedef enum logic [1:0] {
        A_HDR = 2'd0,
        A_HI  = 2'd1,
        A_LO  = 2'd2
    } a_state_t;

    logic             rx_meta_r;
    logic             rxs_r;
    r_state_t         r_state_r;
    r_state_t         r_next_s;
    a_state_t         a_state_r;
    a_state_t         a_next_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic [1:0]       sel_r;
    logic [7:0]       hi_r;

    logic load_half_s;
    logic load_full_s;
    logic cnt_dec_s;
    logic sample_s;
    logic bit_clr_s;
    logic start_det_s;
    logic byte_valid_s;
    logic frame_err_s;
    logic bit_cnt_zero_s;
    logic to_run_s;
    logic timeout_s;
    logic hdr_bad_s;
    logic latch_sel_s;
    logic latch_hi_s;
    logic deliver_s;

    assign bit_cnt_zero_s = (bit_cnt_r == {CNT_W{1'b0}});

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Receiver and assembler state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_r <= R_IDLE;
            a_state_r <= A_HDR;
        end else begin
            r_state_r <= r_next_s;
            a_state_r <= a_next_s;
        end
    end

    // Receiver next-state and per-cycle control strobes.
    always_comb begin
        r_next_s     = r_state_r;
        load_half_s  = 1'b0;
        load_full_s  = 1'b0;
        cnt_dec_s    = 1'b0;
        sample_s     = 1'b0;
        bit_clr_s    = 1'b0;
        start_det_s  = 1'b0;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (!rxs_r) begin
                    r_next_s    = R_START;
                    load_half_s = 1'b1;
                    start_det_s = 1'b1;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_START: begin
                if (bit_cnt_zero_s) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (!rxs_r) begin
                        r_next_s    = R_DATA;
                        load_full_s = 1'b1;
                        bit_clr_s   = 1'b1;
                    end else begin
                        r_next_s = R_IDLE;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            R_DATA: begin
                if (bit_cnt_zero_s) begin
                    sample_s    = 1'b1;
                    load_full_s = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        r_next_s = R_STOP;
                    end else begin
                        r_next_s = R_DATA;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            R_STOP: begin
                if (bit_cnt_zero_s) begin
                    if (rxs_r) begin
                        byte_valid_s = 1'b1;
                        r_next_s     = R_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        r_next_s    = R_WAITHI;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            R_WAITHI: begin
                if (rxs_r) begin
                    r_next_s = R_IDLE;
                end else begin
                    r_next_s = R_WAITHI;
                end
            end
            default: begin
                r_next_s = R_IDLE;
            end
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            if (load_half_s) begin
                bit_cnt_r <= HALF_LOAD;
            end else if (load_full_s) begin
                bit_cnt_r <= FULL_LOAD;
            end else if (cnt_dec_s) begin
                bit_cnt_r <= bit_cnt_r - CNT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (bit_clr_s) begin
                bit_idx_r <= 3'd0;
            end else if (sample_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
            if (sample_s) begin
                shift_r <= {rxs_r, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Assembler next-state; a framing error outranks everything, then timeout, then a new byte.
    always_comb begin
        a_next_s    = a_state_r;
        to_run_s    = 1'b0;
        timeout_s   = 1'b0;
        hdr_bad_s   = 1'b0;
        latch_sel_s = 1'b0;
        latch_hi_s  = 1'b0;
        deliver_s   = 1'b0;
        // A start detect in the same cycle suppresses the timeout.
        if ((a_state_r != A_HDR) && (r_state_r == R_IDLE) && !start_det_s) begin
            to_run_s  = 1'b1;
            timeout_s = (to_cnt_r == TO_LAST);
        end else begin
            to_run_s  = 1'b0;
            timeout_s = 1'b0;
        end
        if (frame_err_s) begin
            a_next_s = A_HDR;
        end else if (timeout_s) begin
            a_next_s = A_HDR;
        end else if (byte_valid_s) begin
            case (a_state_r)
                A_HDR: begin
                    if (shift_r[7:2] == HDR_TAG) begin
                        latch_sel_s = 1'b1;
                        a_next_s    = A_HI;
                    end else begin
                        hdr_bad_s = 1'b1;
                        a_next_s  = A_HDR;
                    end
                end
                A_HI: begin
                    latch_hi_s = 1'b1;
                    a_next_s   = A_LO;
                end
                A_LO: begin
                    deliver_s = 1'b1;
                    a_next_s  = A_HDR;
                end
                default: begin
                    a_next_s = A_HDR;
                end
            endcase
        end else begin
            a_next_s = a_state_r;
        end
    end

    // Inter-byte timeout counter and the partial-frame latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= {TO_W{1'b0}};
            sel_r    <= 2'd0;
            hi_r     <= 8'd0;
        end else begin
            if (start_det_s || timeout_s || (a_state_r == A_HDR)) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (to_run_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (frame_err_s || timeout_s) begin
                sel_r <= 2'd0;
                hi_r  <= 8'd0;
            end else begin
                if (latch_sel_s) begin
                    sel_r <= shift_r[1:0];
                end else begin
                    sel_r <= sel_r;
                end
                if (latch_hi_s) begin
                    hi_r <= shift_r;
                end else begin
                    hi_r <= hi_r;
                end
            end
        end
    end

    // Registered CPU-facing outputs; busy mirrors the states being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_en   <= 1'b0;
            uart_data <= 16'd0;
            uart_sel  <= 2'd0;
            frame_err <= 1'b0;
            proto_err <= 1'b0;
            busy      <= 1'b0;
            word_cnt  <= 16'd0;
        end else begin
            uart_en   <= deliver_s;
            frame_err <= frame_err_s;
            proto_err <= hdr_bad_s | timeout_s;
            busy      <= (r_next_s != R_IDLE) || (a_next_s != A_HDR);
            if (deliver_s) begin
                uart_data <= {hi_r, shift_r};
                uart_sel  <= sel_r;
                word_cnt  <= word_cnt + 16'd1;
            end else begin
                uart_data <= uart_data;
                uart_sel  <= uart_sel;
                word_cnt  <= word_cnt;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: table-driven frames, directed corner cases,
// and random byte streams checked against a frame-level reference model.
module tb_uart_word_loader;

    localparam int CPB = 16;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        uart_en;
    logic [15:0] uart_data;
    logic [1:0]  uart_sel;
    logic        frame_err;
    logic        proto_err;
    logic        busy;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .uart_en   (uart_en),
        .uart_data (uart_data),
        .uart_sel  (uart_sel),
        .frame_err (frame_err),
        .proto_err (proto_err),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Output monitor: counts pulses and records every delivered word.
    int          en_seen = 0;
    int          ferr_seen = 0;
    int          perr_seen = 0;
    int          b2b_seen = 0;
    logic        prev_en = 1'b0;
    logic [15:0] obs_data [0:511];
    logic [1:0]  obs_sel  [0:511];
    logic [15:0] obs_wcnt [0:511];

    always @(negedge clk) begin
        if (!reset) begin
            en_seen   <= 0;
            ferr_seen <= 0;
            perr_seen <= 0;
            prev_en   <= 1'b0;
        end else begin
            if (uart_en) begin
                if (prev_en) b2b_seen <= b2b_seen + 1;
                if (en_seen < 512) begin
                    obs_data[en_seen] <= uart_data;
                    obs_sel[en_seen]  <= uart_sel;
                    obs_wcnt[en_seen] <= word_cnt;
                end
                en_seen <= en_seen + 1;
            end
            if (frame_err) ferr_seen <= ferr_seen + 1;
            if (proto_err) perr_seen <= perr_seen + 1;
            prev_en <= uart_en;
        end
    end

    // Frame-level reference model.
    logic [7:0]  frm_q[$];
    int          exp_words = 0;
    int          exp_ferr = 0;
    int          exp_perr = 0;
    int          chk_ptr = 0;
    logic [15:0] exp_data [0:511];
    logic [1:0]  exp_sel  [0:511];

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_ferr++;
            frm_q.delete();
        end else if (frm_q.size() == 0) begin
            if (b[7:2] == 6'b101010) frm_q.push_back(b);
            else exp_perr++;
        end else begin
            frm_q.push_back(b);
            if (frm_q.size() == 3) begin
                if (exp_words < 512) begin
                    exp_data[exp_words] = {frm_q[1], frm_q[2]};
                    exp_sel[exp_words]  = frm_q[0][1:0];
                end
                exp_words++;
                frm_q.delete();
            end
        end
    endtask

    task automatic model_timeout();
        if (frm_q.size() != 0) begin
            exp_perr++;
            frm_q.delete();
        end
    endtask

    task automatic model_reset();
        frm_q.delete();
        exp_words = 0;
        exp_ferr  = 0;
        exp_perr  = 0;
        chk_ptr   = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serial byte driver; a bad stop bit leaves rx low for the caller to release.
    task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
        model_byte(b, ok);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = ok;
        wait_clks(CPB);
        if (ok) rx = 1'b1;
        wait_clks(gap);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_words"}, en_seen, exp_words);
        check({tag, "_ferr"}, ferr_seen, exp_ferr);
        check({tag, "_perr"}, perr_seen, exp_perr);
        for (int i = chk_ptr; i < en_seen && i < exp_words && i < 512; i++) begin
            check({tag, "_data"}, obs_data[i], exp_data[i]);
            check({tag, "_sel"}, obs_sel[i], exp_sel[i]);
            check({tag, "_wcnt"}, obs_wcnt[i], (i + 1) & 32'hFFFF);
        end
        chk_ptr = en_seen;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, uart_en, 0);
        check({tag, "_data"}, uart_data, 0);
        check({tag, "_sel"}, uart_sel, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_perr"}, proto_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wcnt"}, word_cnt, 0);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          exp_en;
        logic [15:0] exp_data;
        logic [1:0]  exp_sel;
        int          exp_perr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_en;
        int base_perr;
        int base_ferr;
        logic [7:0] rb;
        bit         rok;
        int         rgap;

        vecs[0] = '{8'hA9, 8'h12, 8'h34, 1, 16'h1234, 2'd1, 0};
        vecs[1] = '{8'hA8, 8'hBE, 8'hEF, 1, 16'hBEEF, 2'd0, 0};
        vecs[2] = '{8'hAB, 8'h00, 8'hFF, 1, 16'h00FF, 2'd3, 0};
        vecs[3] = '{8'h55, 8'h12, 8'h34, 0, 16'h0000, 2'd0, 3};
        vecs[4] = '{8'hAA, 8'h77, 8'hA8, 1, 16'h77A8, 2'd2, 0};
        vecs[5] = '{8'hA8, 8'hA8, 8'hA8, 1, 16'hA8A8, 2'd0, 0};

        wait_clks(5);
        check_all_zero("reset");
        reset = 1'b1;
        wait_clks(5);

        // Table-driven 3-byte frames.
        for (int v = 0; v < 6; v++) begin
            base_en   = en_seen;
            base_perr = perr_seen;
            base_ferr = ferr_seen;
            send_byte(vecs[v].b0, 1'b1, 2);
            send_byte(vecs[v].b1, 1'b1, 2);
            send_byte(vecs[v].b2, 1'b1, 2);
            wait_clks(30);
            check("vec_en_count", en_seen - base_en, vecs[v].exp_en);
            check("vec_perr_count", perr_seen - base_perr, vecs[v].exp_perr);
            check("vec_ferr_count", ferr_seen - base_ferr, 0);
            check("vec_busy_idle", busy, 0);
            if (vecs[v].exp_en != 0) begin
                check("vec_data", uart_data, vecs[v].exp_data);
                check("vec_sel", uart_sel, vecs[v].exp_sel);
            end
            checkpoint("vec");
        end

        // Framing error mid-frame, break held low, then a clean frame.
        base_ferr = ferr_seen;
        base_en   = en_seen;
        send_byte(8'hAB, 1'b1, 2);
        send_byte(8'h12, 1'b0, 0);
        wait_clks(40);
        check("ferr_waithi_busy", busy, 1);
        rx = 1'b1;
        wait_clks(20);
        check("ferr_pulses", ferr_seen - base_ferr, 1);
        check("ferr_no_strobe", en_seen - base_en, 0);
        check("ferr_busy_idle", busy, 0);
        send_byte(8'hAB, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'hFF, 1'b1, 2);
        wait_clks(30);
        check("ferr_next_data", uart_data, 16'h00FF);
        check("ferr_next_sel", uart_sel, 2'd3);
        checkpoint("ferr");

        // Inter-byte timeout abandons a 2-byte partial frame.
        base_en   = en_seen;
        base_perr = perr_seen;
        send_byte(8'hAA, 1'b1, 2);
        send_byte(8'h77, 1'b1, 0);
        model_timeout();
        wait_clks(1200);
        check("tmo_no_strobe", en_seen - base_en, 0);
        check("tmo_perr", perr_seen - base_perr, 1);
        check("tmo_busy_idle", busy, 0);
        check("tmo_data_held", uart_data, 16'h00FF);
        send_byte(8'hA8, 1'b1, 2);
        send_byte(8'h01, 1'b1, 2);
        send_byte(8'h02, 1'b1, 2);
        wait_clks(30);
        check("tmo_next_data", uart_data, 16'h0102);
        checkpoint("tmo");

        // Short low glitch is a false start.
        base_en   = en_seen;
        base_perr = perr_seen;
        base_ferr = ferr_seen;
        rx = 1'b0;
        wait_clks(4);
        check("glitch_busy_high", busy, 1);
        rx = 1'b1;
        wait_clks(30);
        check("glitch_busy_low", busy, 0);
        check("glitch_no_en", en_seen - base_en, 0);
        check("glitch_no_perr", perr_seen - base_perr, 0);
        check("glitch_no_ferr", ferr_seen - base_ferr, 0);

        // Reset during the second byte of a frame.
        send_byte(8'hA9, 1'b1, 2);
        rx = 1'b0;
        wait_clks(40);
        check("rst_mid_busy", busy, 1);
        reset = 1'b0;
        rx = 1'b1;
        model_reset();
        wait_clks(3);
        check_all_zero("rst_mid");
        reset = 1'b1;
        wait_clks(40);
        check("rst_after_no_en", en_seen, 0);
        send_byte(8'hA9, 1'b1, 2);
        send_byte(8'hCA, 1'b1, 2);
        send_byte(8'hFE, 1'b1, 2);
        wait_clks(30);
        check("rst_after_data", uart_data, 16'hCAFE);
        check("rst_after_sel", uart_sel, 2'd1);
        check("rst_after_wcnt", word_cnt, 16'd1);
        checkpoint("rst");

        // Random byte stream with occasional bad stop bits and long idles.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 4) rb = {6'b101010, 2'($urandom_range(0, 3))};
            else rb = 8'($urandom);
            rok  = ($urandom_range(0, 29) != 0);
            rgap = ($urandom_range(0, 19) == 0) ? 1100 : $urandom_range(0, 40);
            send_byte(rb, rok, 0);
            if (!rok) begin
                wait_clks($urandom_range(0, 30));
                rx = 1'b1;
                wait_clks(5);
            end
            if (rgap == 1100) model_timeout();
            wait_clks(rgap);
        end
        model_timeout();
        wait_clks(1100);
        checkpoint("rand");
        check("rand_busy_idle", busy, 0);
        check("rand_wcnt", word_cnt, exp_words & 32'hFFFF);
        check("no_back_to_back_en", b2b_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
